imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/cpu_pkg.sv | 18 +
 rtl/imem_loader_cnt.sv | 29 ++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and loader state encoding
package cpu_pkg;
  localparam int IMEM_WORDS = 256;
  localparam int DMEM_BYTES = 32;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int IMEM_AW    = 8;
  localparam int DMEM_AW    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_ARG,
    ST_RUN,
    ST_ERR
  } state_e;
endpackage

// File: rtl/imem_loader_cnt.sv
// rtl/imem_loader_cnt.sv - loadable up-counter with terminal-count flag
module imem_loader_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;

  // Load wins over increment so a phase change restarts cleanly at ld_val_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == max_i);
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - clears memories, streams a program into imem, writes the argument, starts the CPU
module imem_loader #(
  parameter int IMEM_WORDS = cpu_pkg::IMEM_WORDS,
  parameter int ARG_BYTES  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_req_i,
  input  logic [31:0] arg_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  input  logic        s_last_i,
  output logic        imem_we_o,
  output logic [7:0]  imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        dmem_we_o,
  output logic [4:0]  dmem_addr_o,
  output logic [7:0]  dmem_wdata_o,
  output logic        cpu_rstn_o,
  output logic        cpu_start_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  import cpu_pkg::state_e, cpu_pkg::ST_IDLE, cpu_pkg::ST_CLEAR, cpu_pkg::ST_LOAD;
  import cpu_pkg::ST_ARG, cpu_pkg::ST_RUN, cpu_pkg::ST_ERR;

  localparam int AW = cpu_pkg::IMEM_AW;

  state_e                    state_q, state_d;
  logic [cpu_pkg::WORD_W-1:0] arg_q, arg_d;
  logic                      run_q, run_d;
  logic                      cnt_ld, cnt_en, cnt_tc;
  logic [AW-1:0]             cnt;

  imem_loader_cnt #(.W(AW)) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ld_i     (cnt_ld),
    .ld_val_i ('0),
    .en_i     (cnt_en),
    .max_i    (AW'(IMEM_WORDS - 1)),
    .cnt_o    (cnt),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      arg_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    arg_d        = arg_q;
    cnt_ld       = 1'b0;
    cnt_en       = 1'b0;
    s_ready_o    = 1'b0;
    imem_we_o    = 1'b0;
    imem_addr_o  = cnt;
    imem_wdata_o = '0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = cnt[cpu_pkg::DMEM_AW-1:0];
    dmem_wdata_o = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        done_o = (state_q == ST_RUN);
        err_o  = (state_q == ST_ERR);
        if (load_req_i) begin
          state_d = ST_CLEAR;
          arg_d   = arg_i;
          cnt_ld  = 1'b1;
        end
      end
      ST_CLEAR: begin
        busy_o    = 1'b1;
        imem_we_o = 1'b1;
        dmem_we_o = (cnt < AW'(cpu_pkg::DMEM_BYTES));
        cnt_en    = 1'b1;
        if (cnt_tc) begin
          state_d = ST_LOAD;
          cnt_ld  = 1'b1;
        end
      end
      ST_LOAD: begin
        busy_o       = 1'b1;
        s_ready_o    = 1'b1;
        imem_we_o    = s_valid_i;
        imem_wdata_o = s_data_i;
        if (s_valid_i) begin
          if (s_last_i) begin
            state_d = ST_ARG;
            cnt_ld  = 1'b1;
          end else if (cnt_tc) begin
            // Overflow: the word at the top address is kept, the counter does not wrap.
            state_d = ST_ERR;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_ARG: begin
        busy_o       = 1'b1;
        dmem_we_o    = 1'b1;
        dmem_wdata_o = arg_q[{cnt[1:0], 3'b000} +: cpu_pkg::BYTE_W];
        cnt_en       = 1'b1;
        if (cnt == AW'(ARG_BYTES - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    run_d = (state_d == ST_RUN);
  end

  // Both CPU controls follow the registered RUN membership, so they move only on entering or leaving RUN.
  assign cpu_rstn_o  = run_q;
  assign cpu_start_o = run_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_i, load_req_i, s_valid_i, s_last_i;
  logic [31:0] arg_i, s_data_i;
  logic        s_ready_o, imem_we_o, dmem_we_o, cpu_rstn_o, cpu_start_o, busy_o, done_o, err_o;
  logic [7:0]  imem_addr_o, dmem_wdata_o;
  logic [31:0] imem_wdata_o;
  logic [4:0]  dmem_addr_o;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_WORDS(256), .ARG_BYTES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .load_req_i(load_req_i), .arg_i(arg_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .cpu_rstn_o(cpu_rstn_o), .cpu_start_o(cpu_start_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed { logic [7:0] a; logic [31:0] d; } iw_t;
  typedef struct packed { logic [4:0] a; logic [7:0] d; } dw_t;
  iw_t iq[$];
  dw_t dq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  t0 = 0;

  logic [31:0] fib_prog [14] = '{
    32'h00000293, 32'h00100313, 32'h00052383, 32'h00038c63, 32'h006283b3,
    32'h00030293, 32'h00038313, 32'hfff50513, 32'hfe0518e3, 32'h00602223,
    32'h0000006f, 32'h00000013, 32'h00000013, 32'h00000013
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int idx, input logic [31:0] base);
    return (base == 32'h0) ? fib_prog[idx] : base + 32'(idx);
  endfunction

  // Monitor: every write the DUT presents must match the head of its queue.
  initial begin
    iw_t ie;
    dw_t de;
    forever begin
      @(negedge clk);
      #2;
      if (imem_we_o) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL imem_extra: write addr=%0d data=%h, expected no write", imem_addr_o, imem_wdata_o);
        end else begin
          ie = iq.pop_front();
          check("imem_addr", 32'(imem_addr_o), 32'(ie.a));
          check("imem_data", imem_wdata_o, ie.d);
        end
      end
      if (dmem_we_o) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dmem_extra: write addr=%0d data=%h, expected no write", dmem_addr_o, dmem_wdata_o);
        end else begin
          de = dq.pop_front();
          check("dmem_addr", 32'(dmem_addr_o), 32'(de.a));
          check("dmem_data", 32'(dmem_wdata_o), 32'(de.d));
        end
      end
    end
  end

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) iq.push_back('{a: 8'(i), d: word_of(i, base)});
  endtask

  task automatic push_arg(input logic [31:0] a);
    for (int k = 0; k < 4; k++) dq.push_back('{a: 5'(k), d: a[8*k +: 8]});
  endtask

  task automatic do_load(input logic [31:0] a);
    for (int i = 0; i < 256; i++) iq.push_back('{a: 8'(i), d: 32'h0});
    for (int i = 0; i < 32; i++) dq.push_back('{a: 5'(i), d: 8'h0});
    load_req_i = 1'b1;
    arg_i      = a;
    t0         = cyc;
    @(negedge clk);
    load_req_i = 1'b0;
    arg_i      = 32'hDEADBEEF;
    check("clear_busy", 32'(busy_o), 32'd1);
    check("clear_ready", 32'(s_ready_o), 32'd0);
  endtask

  task automatic feed(input int nwords, input int last_idx, input bit toggle,
                      input int rst_idx, input logic [31:0] base);
    int idx = 0;
    int n = 0;
    bit ph = 1'b1;
    bit xfer;
    while (idx < nwords && n < 1000) begin
      s_data_i  = word_of(idx, base);
      s_last_i  = (idx == last_idx);
      s_valid_i = toggle ? ph : 1'b1;
      if (idx == rst_idx && s_ready_o) rst_i = 1'b1;
      #1;
      xfer = s_valid_i && s_ready_o;
      @(negedge clk);
      n++;
      ph = ~ph;
      if (rst_i) begin
        rst_i = 1'b0;
        idx   = nwords;
      end else if (xfer) begin
        idx++;
      end
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL feed_timeout: accepted %0d of %0d words", idx, nwords);
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (cpu_start_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cpu_start_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; load_req_i = 1'b0; arg_i = '0;
    s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_cpu_rstn", 32'(cpu_rstn_o), 32'd0);
    check("rst_start", 32'(cpu_start_o), 32'd0);
    check("rst_ready", 32'(s_ready_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Fibonacci program, n=5, stream valid held high through CLEAR and ARG
    do_load(32'd5);
    push_words(14, 32'h0);
    push_arg(32'd5);
    feed(14, 13, 1'b0, -1, 32'h0);
    s_valid_i = 1'b1;
    s_data_i  = 32'h12345678;
    check("arg_ready", 32'(s_ready_o), 32'd0);
    check("arg_busy", 32'(busy_o), 32'd1);
    wait_start("fib_start");
    s_valid_i = 1'b0;
    check("fib_start_cycle", 32'(cyc - t0), 32'd275);
    check("fib_done", 32'(done_o), 32'd1);
    check("fib_cpu_rstn", 32'(cpu_rstn_o), 32'd1);
    check("fib_busy", 32'(busy_o), 32'd0);

    // Reload from RUN with arg 8, toggling valid, load_req ignored mid-CLEAR
    do_load(32'd8);
    check("reload_start_drop", 32'(cpu_start_o), 32'd0);
    check("reload_rstn_drop", 32'(cpu_rstn_o), 32'd0);
    load_req_i = 1'b1;
    arg_i      = 32'hFF;
    @(negedge clk);
    load_req_i = 1'b0;
    push_words(6, 32'hC0DE0000);
    push_arg(32'd8);
    feed(6, 5, 1'b1, -1, 32'hC0DE0000);
    wait_start("reload_start");

    // 256 words without last: overflow into ERR
    do_load(32'h11223344);
    push_words(256, 32'h10000000);
    feed(256, -1, 1'b0, -1, 32'h10000000);
    s_valid_i = 1'b1;
    check("ovf_err", 32'(err_o), 32'd1);
    check("ovf_start", 32'(cpu_start_o), 32'd0);
    check("ovf_rstn", 32'(cpu_rstn_o), 32'd0);
    check("ovf_ready", 32'(s_ready_o), 32'd0);
    check("ovf_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    s_valid_i = 1'b0;
    check("ovf_err_held", 32'(err_o), 32'd1);
    do_load(32'hA1B2C3D4);
    check("ovf_exit_err", 32'(err_o), 32'd0);
    push_words(1, 32'h55000000);
    push_arg(32'hA1B2C3D4);
    feed(1, 0, 1'b0, -1, 32'h55000000);
    wait_start("ovf_recover_start");

    // Reset while word 7 is being loaded
    do_load(32'd3);
    push_words(8, 32'h70000000);
    feed(8, -1, 1'b0, 7, 32'h70000000);
    s_valid_i = 1'b1;
    #2;
    check("mid_rst_imem_we", 32'(imem_we_o), 32'd0);
    check("mid_rst_dmem_we", 32'(dmem_we_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_ready", 32'(s_ready_o), 32'd0);
    check("mid_rst_rstn", 32'(cpu_rstn_o), 32'd0);
    check("mid_rst_start", 32'(cpu_start_o), 32'd0);
    @(negedge clk);
    s_valid_i = 1'b0;
    do_load(32'h00000102);
    push_words(3, 32'h33000000);
    push_arg(32'h00000102);
    feed(3, 2, 1'b0, -1, 32'h33000000);
    wait_start("fresh_start");
    check("fresh_start_cycle", 32'(cyc - t0), 32'd264);

    repeat (2) @(negedge clk);
    check("imem_queue_drained", 32'(iq.size()), 32'd0);
    check("dmem_queue_drained", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
